// File: rtl/adc_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_if
// Brief    : ADC conversion handshake and result stream of the scan sequencer.
//            master = sequencer side, slave = ADC / result consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_scan_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              adc_start;
    logic [CH_W-1:0]   adc_ch;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;
    logic              res_valid;
    logic [CH_W-1:0]   res_ch;
    logic [DATA_W-1:0] res_data;

    modport master (
        output adc_start, adc_ch, res_valid, res_ch, res_data,
        input  adc_done, adc_data
    );

    modport slave (
        input  adc_start, adc_ch, res_valid, res_ch, res_data,
        output adc_done, adc_data
    );
endinterface
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_sequencer
// Brief    : Walks a channel mask, starting one ADC conversion per selected
//            channel, forwarding results, with periodic or one-shot triggering,
//            conversion timeout and trigger-overrun sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 12,
    parameter int TMO_CYC = 255
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_enable,
    input  logic              cfg_single,
    input  logic [NUM_CH-1:0] cfg_ch_mask,
    input  logic [15:0]       cfg_period,
    input  logic              err_clr,
    output logic              scan_done,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overrun,
    adc_scan_if.master        adc
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        CONV  = 2'd2,
        NEXT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         per_cnt_q, per_cnt_d;
    logic                en_q;
    logic                edge_q;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]     adc_ch_q, adc_ch_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                res_valid_q, res_valid_d;
    logic [CH_W-1:0]     res_ch_q, res_ch_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                err_tmo_q, err_tmo_d;
    logic                err_ovr_q, err_ovr_d;

    logic [15:0]         w_period;
    logic                w_run;
    logic                w_tick;
    logic                w_trigger;
    logic [NUM_CH-1:0]   w_remaining;
    logic                w_set_tmo;
    logic                w_set_ovr;

    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = CH_W'(i);
        end
    endfunction

    // Periodic trigger: free-running counter, tick on wrap, parked at 0 when not in periodic mode
    always_comb begin
        w_period  = (cfg_period == 16'd0) ? 16'd1 : cfg_period;
        w_run     = cfg_enable && !cfg_single;
        w_tick    = w_run && (per_cnt_q == (w_period - 16'd1));
        per_cnt_d = per_cnt_q + 16'd1;
        if (!w_run || w_tick) per_cnt_d = 16'd0;
        w_trigger = w_tick || edge_q;
    end

    // Trigger-side registers: period counter and registered enable edge detector.
    // en_q resets to 1 so an enable already high when reset releases is not an edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            per_cnt_q <= 16'd0;
            en_q      <= 1'b1;
            edge_q    <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            en_q      <= cfg_enable;
            edge_q    <= cfg_enable && !en_q && cfg_single;
        end
    end

    // Scan FSM next state, datapath next values and sticky flag updates
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cur_ch_d    = cur_ch_q;
        adc_ch_d    = adc_ch_q;
        tmo_d       = tmo_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        scan_done   = 1'b0;
        w_set_tmo   = 1'b0;
        w_set_ovr   = w_trigger && (state_q != IDLE);
        w_remaining = mask_q & ~(NUM_CH'(1) << cur_ch_q);

        case (state_q)
            IDLE: begin
                if (w_trigger && (cfg_ch_mask != '0)) begin
                    mask_d   = cfg_ch_mask;
                    cur_ch_d = lowest_ch(cfg_ch_mask);
                    adc_ch_d = lowest_ch(cfg_ch_mask);
                    state_d  = START;
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                if (adc.adc_done) begin
                    res_valid_d = 1'b1;
                    res_ch_d    = cur_ch_q;
                    res_data_d  = adc.adc_data;
                    state_d     = NEXT;
                end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                    w_set_tmo = 1'b1;
                    state_d   = NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            NEXT: begin
                mask_d = w_remaining;
                if (w_remaining != '0) begin
                    cur_ch_d = lowest_ch(w_remaining);
                    adc_ch_d = lowest_ch(w_remaining);
                    state_d  = START;
                end else begin
                    scan_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A set in the same cycle as a clear keeps the flag asserted
        err_tmo_d = w_set_tmo ? 1'b1 : (err_clr ? 1'b0 : err_tmo_q);
        err_ovr_d = w_set_ovr ? 1'b1 : (err_clr ? 1'b0 : err_ovr_q);
    end

    // Scan FSM state and datapath registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            cur_ch_q    <= '0;
            adc_ch_q    <= '0;
            tmo_q       <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cur_ch_q    <= cur_ch_d;
            adc_ch_q    <= adc_ch_d;
            tmo_q       <= tmo_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            err_tmo_q   <= err_tmo_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign adc.adc_start = (state_q == START);
    assign adc.adc_ch    = adc_ch_q;
    assign adc.res_valid = res_valid_q;
    assign adc.res_ch    = res_ch_q;
    assign adc.res_data  = res_data_q;
    assign busy          = (state_q != IDLE);
    assign err_timeout   = err_tmo_q;
    assign err_overrun   = err_ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_scan_sequencer
// Brief    : Self-checking bench for adc_scan_sequencer: table of one-shot scan
//            vectors plus directed periodic, timeout, overrun, mask-change and
//            reset-mid-conversion sequences. A behavioural ADC answers each
//            adc_start after a programmable latency with data 0x100+channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;
    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 12;
    localparam int TMO_CYC = 255;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              cfg_enable = 1'b0;
    logic              cfg_single = 1'b0;
    logic [NUM_CH-1:0] cfg_ch_mask = '0;
    logic [15:0]       cfg_period = 16'd0;
    logic              err_clr = 1'b0;
    logic              scan_done, busy, err_timeout, err_overrun;

    adc_scan_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    adc_scan_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .cfg_enable  (cfg_enable),
        .cfg_single  (cfg_single),
        .cfg_ch_mask (cfg_ch_mask),
        .cfg_period  (cfg_period),
        .err_clr     (err_clr),
        .scan_done   (scan_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .adc         (bus)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    // ADC model controls
    int lat        = 2;
    int no_resp_ch = -1;

    // Monitor records
    int cyc = 0;
    int start_ch[$];
    int start_cyc[$];
    int res_ch_l[$];
    int res_dat_l[$];
    int done_cnt = 0;
    int tmo_cyc  = -1;

    typedef struct {
        logic [3:0]  mask;
        int          n;
        logic [15:0] chs;   // nibble i = i-th converted channel
    } vec_t;

    vec_t vecs[6];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge ACLK);
            #1;
        end
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int k = 0;
        while (start_ch.size() < target && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(start_ch.size() >= target), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    // Behavioural ADC: adc_done one cycle wide, lat cycles after the START cycle
    initial begin
        int pend_cnt;
        int pend_ch;
        pend_cnt = 0;
        pend_ch  = 0;
        bus.adc_done = 1'b0;
        bus.adc_data = '0;
        forever begin
            @(negedge ACLK);
            bus.adc_done = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.adc_done = 1'b1;
                    bus.adc_data = 12'h100 + 12'(pend_ch);
                end
            end
            if (bus.adc_start && int'(bus.adc_ch) != no_resp_ch) begin
                pend_cnt = lat;
                pend_ch  = int'(bus.adc_ch);
            end
        end
    end

    // Monitor: log starts, results, scan ends and the timeout flag rising edge
    initial begin
        logic prev_tmo;
        prev_tmo = 1'b0;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (bus.adc_start) begin
                start_ch.push_back(int'(bus.adc_ch));
                start_cyc.push_back(cyc);
            end
            if (bus.res_valid) begin
                res_ch_l.push_back(int'(bus.res_ch));
                res_dat_l.push_back(int'(bus.res_data));
            end
            if (scan_done) done_cnt++;
            if (err_timeout && !prev_tmo) tmo_cyc = cyc;
            prev_tmo = err_timeout;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_s, b_r, b_d, gap, lows;

        vecs[0] = '{mask: 4'b0001, n: 1, chs: 16'h0000};
        vecs[1] = '{mask: 4'b1011, n: 3, chs: 16'h0310};
        vecs[2] = '{mask: 4'b1000, n: 1, chs: 16'h0003};
        vecs[3] = '{mask: 4'b0110, n: 2, chs: 16'h0021};
        vecs[4] = '{mask: 4'b1111, n: 4, chs: 16'h3210};
        vecs[5] = '{mask: 4'b0000, n: 0, chs: 16'h0000};

        // Reset state
        step(3);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_adc_start", 32'(bus.adc_start), 32'd0);
        check("rst_adc_ch",    32'(bus.adc_ch),    32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data",  32'(bus.res_data),  32'd0);
        check("rst_scan_done", 32'(scan_done),     32'd0);
        check("rst_err_tmo",   32'(err_timeout),   32'd0);
        check("rst_err_ovr",   32'(err_overrun),   32'd0);
        ARESET = 1'b0;
        step(2);

        // One-shot scans from the vector table
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            cfg_single  = 1'b1;
            cfg_enable  = 1'b0;
            cfg_ch_mask = v.mask;
            lat         = 2;
            step(3);
            b_s = start_ch.size();
            b_r = res_ch_l.size();
            b_d = done_cnt;
            cfg_enable = 1'b1;
            if (v.n > 0) wait_done(b_d + 1, 100, "vec_scan_done_wait");
            else step(30);
            step(20);  // enable stays high: no retrigger expected
            check("vec_nstart", 32'(start_ch.size() - b_s), 32'(v.n));
            check("vec_nres",   32'(res_ch_l.size() - b_r), 32'(v.n));
            check("vec_ndone",  32'(done_cnt - b_d), 32'(v.n > 0));
            for (int j = 0; j < v.n; j++) begin
                if (b_s + j < start_ch.size())
                    check("vec_start_ch", 32'(start_ch[b_s + j]), 32'(v.chs[4*j +: 4]));
                if (b_r + j < res_ch_l.size()) begin
                    check("vec_res_ch",   32'(res_ch_l[b_r + j]),  32'(v.chs[4*j +: 4]));
                    check("vec_res_data", 32'(res_dat_l[b_r + j]), 32'h100 + 32'(v.chs[4*j +: 4]));
                end
            end
            check("vec_idle", 32'(busy), 32'd0);
            cfg_enable = 1'b0;
        end

        // Periodic scans: mask 1011, period 100, ADC latency 3
        step(3);
        cfg_single  = 1'b0;
        cfg_ch_mask = 4'b1011;
        cfg_period  = 16'd100;
        lat         = 3;
        b_s = start_ch.size();
        b_r = res_ch_l.size();
        b_d = done_cnt;
        cfg_enable = 1'b1;
        wait_starts(b_s + 6, 300, "per_starts_wait");
        cfg_enable = 1'b0;
        step(30);
        if (start_ch.size() >= b_s + 6) begin
            check("per_ch0a", 32'(start_ch[b_s + 0]), 32'd0);
            check("per_ch1a", 32'(start_ch[b_s + 1]), 32'd1);
            check("per_ch3a", 32'(start_ch[b_s + 2]), 32'd3);
            check("per_ch0b", 32'(start_ch[b_s + 3]), 32'd0);
            check("per_interval", 32'(start_cyc[b_s + 3] - start_cyc[b_s]), 32'd100);
        end
        check("per_nres", 32'(res_ch_l.size() - b_r), 32'd6);
        if (res_dat_l.size() >= b_r + 3) begin
            check("per_data0", 32'(res_dat_l[b_r + 0]), 32'h100);
            check("per_data1", 32'(res_dat_l[b_r + 1]), 32'h101);
            check("per_data3", 32'(res_dat_l[b_r + 2]), 32'h103);
        end
        check("per_ndone", 32'(done_cnt - b_d), 32'd2);
        check("per_no_extra", 32'(start_ch.size() - b_s), 32'd6);

        // Timeout: channel 2 never answers
        cfg_single  = 1'b1;
        cfg_ch_mask = 4'b0100;
        no_resp_ch  = 2;
        step(3);
        b_s = start_ch.size();
        b_r = res_ch_l.size();
        b_d = done_cnt;
        cfg_enable = 1'b1;
        wait_done(b_d + 1, 400, "tmo_done_wait");
        if (start_ch.size() > b_s) begin
            check("tmo_ch", 32'(start_ch[b_s]), 32'd2);
            // CONV entered the cycle after START; flag visible 255 cycles later
            check("tmo_latency", 32'(tmo_cyc - start_cyc[b_s]), 32'd256);
        end
        check("tmo_flag", 32'(err_timeout), 32'd1);
        check("tmo_no_res", 32'(res_ch_l.size() - b_r), 32'd0);
        check("tmo_ndone", 32'(done_cnt - b_d), 32'd1);
        pulse_err_clr();
        check("tmo_clr", 32'(err_timeout), 32'd0);
        cfg_enable = 1'b0;
        no_resp_ch = -1;

        // Overrun: period 4, conversions of 10 cycles
        step(3);
        cfg_single  = 1'b0;
        cfg_ch_mask = 4'b0001;
        cfg_period  = 16'd4;
        lat         = 10;
        b_s = start_ch.size();
        cfg_enable = 1'b1;
        wait_starts(b_s + 3, 200, "ovr_starts_wait");
        lows = 0;
        for (int k = 0; k < 11; k++) begin
            if (!busy) lows++;
            step(1);
        end
        check("ovr_busy_hold", 32'(lows), 32'd0);
        check("ovr_flag", 32'(err_overrun), 32'd1);
        if (start_cyc.size() >= b_s + 3) begin
            gap = start_cyc[b_s + 1] - start_cyc[b_s];
            check("ovr_no_overlap1", 32'(gap >= 13), 32'd1);
            gap = start_cyc[b_s + 2] - start_cyc[b_s + 1];
            check("ovr_no_overlap2", 32'(gap >= 13), 32'd1);
        end
        cfg_enable = 1'b0;
        step(30);
        pulse_err_clr();
        check("ovr_clr", 32'(err_overrun), 32'd0);

        // Mask change during the first conversion does not alter the running scan
        cfg_ch_mask = 4'b1111;
        cfg_period  = 16'd100;
        lat         = 3;
        b_s = start_ch.size();
        b_d = done_cnt;
        cfg_enable = 1'b1;
        wait_starts(b_s + 1, 150, "msk_first_wait");
        step(1);
        cfg_ch_mask = 4'b0001;
        wait_starts(b_s + 5, 250, "msk_starts_wait");
        cfg_enable = 1'b0;
        step(30);
        if (start_ch.size() >= b_s + 5) begin
            check("msk_ch1", 32'(start_ch[b_s + 1]), 32'd1);
            check("msk_ch2", 32'(start_ch[b_s + 2]), 32'd2);
            check("msk_ch3", 32'(start_ch[b_s + 3]), 32'd3);
            check("msk_next_ch0", 32'(start_ch[b_s + 4]), 32'd0);
        end
        check("msk_next_only", 32'(start_ch.size() - b_s), 32'd5);
        check("msk_ndone", 32'(done_cnt - b_d), 32'd2);

        // Reset asserted mid-CONV on channel 2
        cfg_ch_mask = 4'b0100;
        cfg_period  = 16'd50;
        lat         = 5;
        b_s = start_ch.size();
        cfg_enable = 1'b1;
        wait_starts(b_s + 1, 80, "rstc_first_wait");
        step(2);
        b_r = res_ch_l.size();
        b_d = done_cnt;
        check("rstc_pre_busy", 32'(busy), 32'd1);
        #1 ARESET = 1'b1;
        #1;
        check("rstc_busy",      32'(busy),          32'd0);
        check("rstc_adc_start", 32'(bus.adc_start), 32'd0);
        check("rstc_adc_ch",    32'(bus.adc_ch),    32'd0);
        check("rstc_res_valid", 32'(bus.res_valid), 32'd0);
        check("rstc_res_ch",    32'(bus.res_ch),    32'd0);
        check("rstc_res_data",  32'(bus.res_data),  32'd0);
        check("rstc_scan_done", 32'(scan_done),     32'd0);
        step(2);
        ARESET = 1'b0;
        wait_starts(b_s + 2, 80, "rstc_resume_wait");
        check("rstc_no_res", 32'(res_ch_l.size() - b_r), 32'd0);
        check("rstc_no_done", 32'(done_cnt - b_d), 32'd0);
        wait_done(b_d + 1, 30, "rstc_done_wait");
        if (res_dat_l.size() > b_r)
            check("rstc_resume_data", 32'(res_dat_l[b_r]), 32'h102);
        cfg_enable = 1'b0;
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4: number of ADC channels scanned.
REQ-002 The module SHALL have parameter DATA_W, default 12: ADC result width.
REQ-003 The module SHALL have parameter TMO_CYC, default 255: maximum CONV cycles allowed before a timeout.
REQ-004 The module SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port ARESET, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port cfg_enable, input, 1 bit: scanning enabled.
REQ-007 The module SHALL have port cfg_single, input, 1 bit: one scan per cfg_enable rising edge instead of periodic scans.
REQ-008 The module SHALL have port cfg_ch_mask, input, NUM_CH bits: channels included in a scan.
REQ-009 The module SHALL have port cfg_period, input, 16 bits: cycles between periodic scan triggers; 0 is treated as 1.
REQ-010 The module SHALL have port err_clr, input, 1 bit: clears sticky error flags.
REQ-011 The module SHALL have port adc_start, output, 1 bit: conversion start pulse.
REQ-012 The module SHALL have port adc_ch, output, clog2(NUM_CH) bits: channel being converted.
REQ-013 The module SHALL have port adc_done, input, 1 bit: conversion complete.
REQ-014 The module SHALL have port adc_data, input, DATA_W bits: result, valid when adc_done=1.
REQ-015 The module SHALL have ports res_valid (output, 1 bit), res_ch (output, clog2(NUM_CH) bits) and res_data (output, DATA_W bits): the result strobe and its payload.
REQ-016 The module SHALL have ports scan_done (output, 1 bit) and busy (output, 1 bit): end-of-scan pulse and a scan-in-progress level.
REQ-017 The module SHALL have ports err_timeout (output, 1 bit) and err_overrun (output, 1 bit): sticky error flags.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, START, CONV and NEXT; busy = (state != IDLE).
REQ-019 Period counter SHALL run only while cfg_enable=1 and cfg_single=0, count 0..max(cfg_period,1)-1, and assert a one-cycle tick on wrap; it SHALL hold 0 while cfg_enable=0.
REQ-020 Trigger SHALL be the tick in periodic mode; in single mode it SHALL be the cycle after a registered cfg_enable 0->1 edge is detected.
REQ-021 IDLE, on trigger with cfg_ch_mask != 0: the FSM SHALL latch cfg_ch_mask into a shadow mask, select the lowest set bit as the channel and go to START next cycle; a trigger with mask=0 SHALL be ignored.
REQ-022 START SHALL last 1 cycle with adc_start=1 and adc_ch=selected channel, clear the timeout counter and go to CONV.
REQ-023 CONV: adc_done=1 SHALL capture adc_data and the channel, assert res_valid for exactly 1 cycle on the following cycle, and go to NEXT.
REQ-024 CONV: if TMO_CYC cycles elapse without adc_done, err_timeout SHALL be set, no res_valid SHALL be emitted, and the FSM SHALL go to NEXT.
REQ-025 NEXT SHALL clear the current bit in the shadow mask; if bits remain, it SHALL select the lowest remaining bit and go to START; otherwise it SHALL pulse scan_done for 1 cycle and go to IDLE.
REQ-026 Per-channel latency SHALL be START (1) + CONV (>=1) + NEXT (1) cycles; res_valid SHALL coincide with the NEXT cycle.
REQ-027 adc_done outside CONV SHALL be ignored; adc_ch SHALL hold its last value outside START/CONV.
REQ-028 Changes to cfg_ch_mask mid-scan SHALL NOT affect the running scan (shadow mask).
REQ-029 cfg_enable 1->0 mid-scan SHALL let the scan complete normally; no further triggers SHALL occur.
REQ-030 A trigger while busy=1 SHALL be dropped and SHALL set err_overrun.
REQ-031 err_clr SHALL clear both flags; if a set condition occurs in the same cycle as err_clr, set SHALL win.

Reset
REQ-032 ARESET=1 SHALL immediately force state=IDLE, counters, shadow mask and capture registers to 0, and adc_start, res_valid, scan_done, busy, err_timeout, err_overrun, adc_ch, res_ch and res_data to 0.
REQ-033 Reset asserted mid-conversion SHALL abort without emitting res_valid or scan_done; after release the block SHALL wait for a fresh trigger, and in single mode a cfg_enable already high SHALL NOT count as an edge.

Verification
REQ-034 A bench SHALL cover a periodic scan: mask=4'b1011, period=100, adc_done 3 cycles after each start with data 0x100+ch -> adc_start on ch 0, 1, 3 in order; res_data 0x100, 0x101, 0x103; one scan_done; next scan starts 100 cycles after the previous.
REQ-035 A bench SHALL cover single mode: cfg_single=1, cfg_enable pulsed 0->1 once, mask=4'b0001 -> exactly one conversion and one scan_done; no further adc_start while enable stays high.
REQ-036 A bench SHALL cover timeout: adc_done never asserted on ch 2, mask=4'b0100 -> err_timeout set 255 cycles after entering CONV; no res_valid; scan_done pulsed; err_clr clears the flag.
REQ-037 A bench SHALL cover overrun: period=4, conversions taking 10 cycles -> err_overrun set; scans never overlap; busy continuous.
REQ-038 A bench SHALL cover mask change mid-scan: mask 4'b1111 changed to 4'b0001 during the ch 0 conversion -> ch 1, 2, 3 are still converted in that scan; the next scan converts ch 0 only.
REQ-039 A bench SHALL cover reset mid-CONV: ARESET pulsed while in CONV -> all outputs 0 asynchronously; no res_valid; normal scans resume on the next tick.
